pe_mac_pipe: RTL and testbench
==============================

PE_MAC_PIPE -- requirements
Module: pe_mac_pipe

Interface
REQ-001 Parameter DATA_W, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter ACC_W, default 32, accumulator width; must satisfy ACC_W >= 2*DATA_W, otherwise elaboration fails.
REQ-003 Parameter SIGNED, default 0: 0 = unsigned operands and accumulator; 1 = two's-complement.
REQ-004 Parameter SATURATE, default 1: 1 = clamp accumulator on overflow; 0 = wrap modulo 2^ACC_W.
REQ-005 i_clk  input  1  clock; all state updates on rising edge.
REQ-006 i_arst  input  1  reset, asynchronous, active-high.
REQ-007 i_clear  input  1  synchronous accumulator/overflow clear.
REQ-008 i_valid  input  1  i_a/i_b carry a valid operand pair this cycle.
REQ-009 i_a  input  DATA_W  operand from west neighbour.
REQ-010 i_b  input  DATA_W  operand from north neighbour.
REQ-011 o_a  output  DATA_W  registered i_a, forwarded east.
REQ-012 o_b  output  DATA_W  registered i_b, forwarded south.
REQ-013 o_valid  output  1  registered i_valid, forwarded with o_a/o_b.
REQ-014 o_y  output  ACC_W  accumulator value (registered).
REQ-015 o_ovf  output  1  sticky overflow flag (registered).

Function
REQ-016 Forward path SHALL load o_a<=i_a and o_b<=i_b only on edges where i_valid=1; otherwise they hold.
REQ-017 o_valid SHALL equal i_valid delayed one cycle on every edge, independent of i_clear.
REQ-018 Stage 1 SHALL register the product p = i_a*i_b (2*DATA_W bits, signed or unsigned per SIGNED) and a product-valid bit pv = i_valid on every edge.
REQ-019 Stage 2 SHALL, when pv=1 and i_clear=0, update acc <= acc + ext(p), ext = sign- or zero-extension to ACC_W per SIGNED.
REQ-020 Latency: an operand pair with i_valid high at edge N SHALL be reflected in o_y after edge N+1.
REQ-021 When pv=0 and i_clear=0, acc and o_ovf SHALL hold.
REQ-022 Overflow is detected when the true sum lies outside the ACC_W range (unsigned: carry-out; signed: operands of equal sign and result of opposite sign).
REQ-023 On overflow with SATURATE=1, acc SHALL load the maximum value (unsigned all-ones; signed 2^(ACC_W-1)-1) or, for signed negative overflow, the minimum value -2^(ACC_W-1).
REQ-024 On overflow with SATURATE=0, acc SHALL load the wrapped sum.
REQ-025 o_ovf SHALL set on any overflow and remain set until i_clear or reset.
REQ-026 Once saturated, further accumulation in the same direction SHALL keep acc at the limit; accumulation in the opposite direction SHALL proceed from the limit.
REQ-027 i_clear=1 SHALL set acc<=0 and o_ovf<=0 at that edge, discarding the stage-1 product consumed at that edge (clear has priority).
REQ-028 An operand pair with i_valid=1 at the same edge as i_clear SHALL still be captured into stage 1 and accumulated onto zero at the next edge (back-to-back tile start, no bubble).
REQ-029 No input combination SHALL stall or back-pressure; the block accepts one operand pair per cycle.

Reset
REQ-030 While i_arst=1, o_a, o_b, o_y, p, and the accumulator SHALL be 0, and o_valid, pv, and o_ovf SHALL be 0, asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight products; after deassertion, the first accumulation SHALL occur one edge after the first i_valid.

Verification
REQ-032 Defaults: i_valid high for 3 cycles with (a,b)=(3,4),(5,6),(255,255) -> o_y 12, 42, 65067 on consecutive cycles; o_a/o_b/o_valid track inputs with one-cycle delay.
REQ-033 DATA_W=8, ACC_W=16, SIGNED=0, SATURATE=1: accumulate 255*255 twice -> o_y=65025 then 65535, o_ovf=1; SATURATE=0 gives 64514, o_ovf=1.
REQ-034 SIGNED=1, DATA_W=8, ACC_W=16: (-128)*(-128) repeated -> 16384, 32767 saturated with o_ovf=1; then (-128)*(127) -> 32767-16256=16511.
REQ-035 i_clear and i_valid (a,b)=(2,3) on the same edge while acc=100 and a product in flight -> o_y=0 after that edge, 6 after the next, o_ovf=0.
REQ-036 i_valid toggling 1,0,1 with i_a=7,9,11 and i_b=1 -> o_a holds 7 during the gap; o_y=7 then 18.
REQ-037 Assert i_arst for one cycle between two valid pairs -> all outputs 0 immediately; only the post-reset pair is accumulated.

Source files
------------

// File: rtl/pe_mac_if.sv
// Operand/result bundle of one systolic MAC processing element.
// The master drives operands and clear; the slave (the PE) returns the
// forwarded operands and the accumulator state.
interface pe_mac_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
);
   logic              i_clear;
   logic              i_valid;
   logic [DATA_W-1:0] i_a;
   logic [DATA_W-1:0] i_b;
   logic [DATA_W-1:0] o_a;
   logic [DATA_W-1:0] o_b;
   logic              o_valid;
   logic [ACC_W-1:0]  o_y;
   logic              o_ovf;

   modport master (
      output i_clear, i_valid, i_a, i_b,
      input  o_a, o_b, o_valid, o_y, o_ovf
   );

   modport slave (
      input  i_clear, i_valid, i_a, i_b,
      output o_a, o_b, o_valid, o_y, o_ovf
   );
endinterface

// File: rtl/pe_mac_pipe.sv
// Two-stage multiply-accumulate processing element for a systolic array.
// Stage 1 registers the product, stage 2 folds it into a saturating or
// wrapping accumulator. Operands are forwarded east/south one cycle late.
module pe_mac_pipe #(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 32,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 1
) (
   input logic     i_clk,
   input logic     i_arst,
   pe_mac_if.slave bus
);
   localparam int PROD_W = 2 * DATA_W;
   localparam int MSB    = ACC_W - 1;

   generate
      if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
         $error("pe_mac_pipe: DATA_W must lie in 2..32");
      end
      if (ACC_W < PROD_W) begin : g_bad_acc_w
         $error("pe_mac_pipe: ACC_W must be at least 2*DATA_W");
      end
   endgenerate

   logic [DATA_W-1:0]        a_q, b_q;
   logic                     valid_q;
   logic signed [PROD_W-1:0] a_s, b_s;
   logic [PROD_W-1:0]        a_u, b_u;
   logic [PROD_W-1:0]        prod_d, prod_q;
   logic                     pv_q;
   logic [ACC_W-1:0]         ext;
   logic [ACC_W:0]           sum;
   logic                     overflow;
   logic [ACC_W-1:0]         sat_val;
   logic [ACC_W-1:0]         acc_d, acc_q;
   logic                     ovf_d, ovf_q;

   // Forward path: operands move on only with a valid pair, valid moves every cycle.
   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.i_valid;
         if (bus.i_valid) begin
            a_q <= bus.i_a;
            b_q <= bus.i_b;
         end
      end
   end

   // Full-width product of the current operand pair, signed or unsigned.
   always_comb begin
      a_s = PROD_W'($signed(bus.i_a));
      b_s = PROD_W'($signed(bus.i_b));
      a_u = PROD_W'(bus.i_a);
      b_u = PROD_W'(bus.i_b);
      if (SIGNED != 0) prod_d = a_s * b_s;
      else             prod_d = a_u * b_u;
   end

   // Stage 1: product and its valid bit are captured on every edge, clear or not.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         prod_q <= '0;
         pv_q   <= 1'b0;
      end else begin
         prod_q <= prod_d;
         pv_q   <= bus.i_valid;
      end
   end

   // Accumulator next state: extend, add, detect overflow, then clamp or wrap.
   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      ext      = (SIGNED != 0) ? ACC_W'($signed(prod_q)) : ACC_W'(prod_q);
      sum      = {1'b0, acc_q} + {1'b0, ext};
      overflow = (SIGNED != 0)
               ? ((acc_q[MSB] == ext[MSB]) && (sum[MSB] != acc_q[MSB]))
               : sum[ACC_W];
      // Signed overflow direction follows the shared operand sign.
      if (SIGNED != 0) sat_val = acc_q[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
      else             sat_val = '1;
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (bus.i_clear) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (pv_q) begin
         ovf_d = ovf_q | overflow;
         acc_d = (overflow && SATURATE != 0) ? sat_val : sum[MSB:0];
      end
   end

   // Stage 2: accumulator and sticky overflow registers.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign bus.o_a     = a_q;
   assign bus.o_b     = b_q;
   assign bus.o_valid = valid_q;
   assign bus.o_y     = acc_q;
   assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_pe_mac_pipe.sv
// Bench for pe_mac_pipe: five parameter variants share one input stream and
// are compared against an integer-arithmetic model of the accumulator.
module tb_pe_mac_pipe;
   localparam int NCFG = 5;

   logic       clk = 1'b0;
   logic       arst;
   logic       clear, valid;
   logic [7:0] a, b;

   always #5 clk = ~clk;

   pe_mac_if #(.DATA_W(8), .ACC_W(32)) if0 ();
   pe_mac_if #(.DATA_W(8), .ACC_W(16)) if1 ();
   pe_mac_if #(.DATA_W(8), .ACC_W(16)) if2 ();
   pe_mac_if #(.DATA_W(8), .ACC_W(16)) if3 ();
   pe_mac_if #(.DATA_W(8), .ACC_W(16)) if4 ();

   assign if0.i_clear = clear; assign if0.i_valid = valid; assign if0.i_a = a; assign if0.i_b = b;
   assign if1.i_clear = clear; assign if1.i_valid = valid; assign if1.i_a = a; assign if1.i_b = b;
   assign if2.i_clear = clear; assign if2.i_valid = valid; assign if2.i_a = a; assign if2.i_b = b;
   assign if3.i_clear = clear; assign if3.i_valid = valid; assign if3.i_a = a; assign if3.i_b = b;
   assign if4.i_clear = clear; assign if4.i_valid = valid; assign if4.i_a = a; assign if4.i_b = b;

   pe_mac_pipe dut0 (.i_clk(clk), .i_arst(arst), .bus(if0.slave));
   pe_mac_pipe #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1))
      dut1 (.i_clk(clk), .i_arst(arst), .bus(if1.slave));
   pe_mac_pipe #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1))
      dut2 (.i_clk(clk), .i_arst(arst), .bus(if2.slave));
   pe_mac_pipe #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(0))
      dut3 (.i_clk(clk), .i_arst(arst), .bus(if3.slave));
   pe_mac_pipe #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0))
      dut4 (.i_clk(clk), .i_arst(arst), .bus(if4.slave));

   int vectors     = 0;
   int miscompares = 0;

   // Variant description: accumulator width, signedness, saturation.
   int cfg_w   [NCFG] = '{32, 16, 16, 16, 16};
   bit cfg_s   [NCFG] = '{0, 0, 1, 0, 1};
   bit cfg_sat [NCFG] = '{1, 1, 1, 0, 0};

   // Reference state: accumulator as a true integer value per variant.
   longint     m_acc [NCFG];
   bit         m_ovf [NCFG];
   bit         m_pv;
   logic [7:0] m_pa, m_pb;
   logic [7:0] m_fa, m_fb;
   bit         m_fv;

   function automatic longint prod_of(input bit s, input logic [7:0] x, input logic [7:0] y);
      if (s) return longint'($signed(x)) * longint'($signed(y));
      return longint'(x) * longint'(y);
   endfunction

   function automatic longint lo_of(input int k);
      return cfg_s[k] ? -(longint'(1) << (cfg_w[k] - 1)) : 0;
   endfunction

   function automatic longint hi_of(input int k);
      return cfg_s[k] ? (longint'(1) << (cfg_w[k] - 1)) - 1 : (longint'(1) << cfg_w[k]) - 1;
   endfunction

   function automatic longint wrap_of(input int k, input longint t);
      longint m, r;
      m = longint'(1) << cfg_w[k];
      r = t % m;
      if (r < 0) r += m;
      if (cfg_s[k] && r >= m / 2) r -= m;
      return r;
   endfunction

   function automatic logic [63:0] exp_y(input int k);
      longint mask;
      mask = (longint'(1) << cfg_w[k]) - 1;
      return 64'(m_acc[k] & mask);
   endfunction

   function automatic logic [63:0] got_y(input int k);
      case (k)
         0:       return 64'(if0.o_y);
         1:       return 64'(if1.o_y);
         2:       return 64'(if2.o_y);
         3:       return 64'(if3.o_y);
         default: return 64'(if4.o_y);
      endcase
   endfunction

   function automatic logic got_ovf(input int k);
      case (k)
         0:       return if0.o_ovf;
         1:       return if1.o_ovf;
         2:       return if2.o_ovf;
         3:       return if3.o_ovf;
         default: return if4.o_ovf;
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NCFG; k++) begin
         m_acc[k] = 0;
         m_ovf[k] = 1'b0;
      end
      m_pv = 1'b0; m_pa = '0; m_pb = '0;
      m_fa = '0;   m_fb = '0; m_fv = 1'b0;
   endtask

   // One rising edge of the reference: accumulate the pending pair, then capture inputs.
   task automatic model_edge(input bit cl, input bit v, input logic [7:0] x, input logic [7:0] y);
      longint t;
      for (int k = 0; k < NCFG; k++) begin
         if (cl) begin
            m_acc[k] = 0;
            m_ovf[k] = 1'b0;
         end else if (m_pv) begin
            t = m_acc[k] + prod_of(cfg_s[k], m_pa, m_pb);
            if (t < lo_of(k) || t > hi_of(k)) begin
               m_ovf[k] = 1'b1;
               if (cfg_sat[k]) m_acc[k] = (t > hi_of(k)) ? hi_of(k) : lo_of(k);
               else            m_acc[k] = wrap_of(k, t);
            end else begin
               m_acc[k] = t;
            end
         end
      end
      m_pv = v;
      m_pa = x;
      m_pb = y;
      m_fv = v;
      if (v) begin
         m_fa = x;
         m_fb = y;
      end
   endtask

   task automatic check1(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < NCFG; k++) begin
         check1($sformatf("%s y[%0d]", tag, k), got_y(k), exp_y(k));
         check1($sformatf("%s ovf[%0d]", tag, k), 64'(got_ovf(k)), 64'(m_ovf[k]));
      end
      check1({tag, " o_a"}, 64'(if0.o_a), 64'(m_fa));
      check1({tag, " o_b"}, 64'(if0.o_b), 64'(m_fb));
      check1({tag, " o_valid"}, 64'(if0.o_valid), 64'(m_fv));
   endtask

   // Apply one input vector across a rising edge and check 1 time unit later.
   task automatic step(input bit cl, input bit v, input logic [7:0] x, input logic [7:0] y,
                       input string tag);
      clear = cl; valid = v; a = x; b = y;
      @(posedge clk);
      model_edge(cl, v, x, y);
      #1;
      check_all(tag);
   endtask

   // Mid-cycle asynchronous reset pulse; outputs must drop before any edge.
   task automatic pulse_reset(input string tag);
      #2 arst = 1'b1;
      #1 model_reset();
      check_all(tag);
      #1 arst = 1'b0;
   endtask

   initial begin
      arst = 1'b1;
      clear = 1'b0; valid = 1'b0; a = '0; b = '0;
      #2 model_reset();
      check_all("reset");
      #1 arst = 1'b0;

      // Default three-pair sequence, pipelined result 12, 42, 65067.
      step(0, 1, 8'd3,   8'd4,   "seq32_0");
      step(0, 1, 8'd5,   8'd6,   "seq32_1");
      check1("seq32 y=12", got_y(0), 64'd12);
      step(0, 1, 8'd255, 8'd255, "seq32_2");
      check1("seq32 y=42", got_y(0), 64'd42);
      step(0, 0, 8'd0,   8'd0,   "seq32_3");
      check1("seq32 y=65067", got_y(0), 64'd65067);

      // Unsigned 16-bit overflow: saturate to 65535 or wrap to 64514.
      step(1, 0, 8'd0,   8'd0,   "ovfu_clr");
      step(0, 1, 8'd255, 8'd255, "ovfu_0");
      step(0, 1, 8'd255, 8'd255, "ovfu_1");
      check1("ovfu sat y=65025", got_y(1), 64'd65025);
      step(0, 1, 8'd255, 8'd255, "ovfu_2");
      check1("ovfu sat y=65535", got_y(1), 64'd65535);
      check1("ovfu wrap y=64514", got_y(3), 64'd64514);
      step(0, 0, 8'd0,   8'd0,   "ovfu_3");
      check1("ovfu sat held", got_y(1), 64'd65535);

      // Signed 16-bit positive saturation, then descend from the limit.
      step(1, 0, 8'h00, 8'h00, "ovfs_clr");
      step(0, 1, 8'h80, 8'h80, "ovfs_0");
      step(0, 1, 8'h80, 8'h80, "ovfs_1");
      check1("ovfs y=16384", got_y(2), 64'd16384);
      step(0, 1, 8'h80, 8'h7f, "ovfs_2");
      check1("ovfs y=32767", got_y(2), 64'd32767);
      check1("ovfs ovf=1", 64'(got_ovf(2)), 64'd1);
      step(0, 0, 8'h00, 8'h00, "ovfs_3");
      check1("ovfs y=16511", got_y(2), 64'd16511);

      // Clear coinciding with a new pair while another product is in flight.
      step(1, 0, 8'd0,  8'd0,  "clr_0");
      step(0, 1, 8'd10, 8'd10, "clr_1");
      step(0, 1, 8'd7,  8'd7,  "clr_2");
      check1("clr y=100", got_y(0), 64'd100);
      step(1, 1, 8'd2,  8'd3,  "clr_3");
      check1("clr y=0", got_y(0), 64'd0);
      step(0, 0, 8'd0,  8'd0,  "clr_4");
      check1("clr y=6", got_y(0), 64'd6);

      // Valid gap: forwarded operand holds, accumulator holds.
      step(1, 0, 8'd0,  8'd0, "gap_clr");
      step(0, 1, 8'd7,  8'd1, "gap_0");
      step(0, 0, 8'd9,  8'd1, "gap_1");
      check1("gap o_a=7", 64'(if0.o_a), 64'd7);
      check1("gap y=7", got_y(0), 64'd7);
      step(0, 1, 8'd11, 8'd1, "gap_2");
      step(0, 0, 8'd0,  8'd0, "gap_3");
      check1("gap y=18", got_y(0), 64'd18);

      // Reset between two pairs discards the in-flight product.
      step(1, 0, 8'd0, 8'd0, "rst_clr");
      step(0, 1, 8'd3, 8'd4, "rst_0");
      step(0, 1, 8'd1, 8'd1, "rst_1");
      pulse_reset("rst_mid");
      check1("rst y=0", got_y(0), 64'd0);
      step(0, 1, 8'd5, 8'd6, "rst_2");
      step(0, 0, 8'd0, 8'd0, "rst_3");
      check1("rst y=30", got_y(0), 64'd30);

      // Randomized traffic with occasional clears and resets.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(63) == 0) pulse_reset("rnd_rst");
         step($urandom_range(15) == 0, $urandom_range(3) != 0,
              8'($urandom), 8'($urandom), "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
